// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER = 32;
    localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    typedef enum logic [1:0] {NOP, ADD, SUB} booth_t;

    // Radix-2 Booth recoding of the current multiplier bit and the bit shifted out last.
    function automatic booth_t booth_decode(input logic m0, input logic qm1);
        case ({m0, qm1})
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/multdiv_ctrl.sv
// Sequencer for multdiv_unit: state machine, iteration counter, start priority and ready strobe.
module multdiv_ctrl #(
    parameter int ITER = 32
) (
    input  logic clock,
    input  logic reset_n,
    input  logic ctrl_MULT,
    input  logic ctrl_DIV,
    output logic load_mult,
    output logic load_div,
    output logic iterate,
    output logic finalise,
    output logic mode_div,
    output logic ready
);
    import multdiv_pkg::*;

    state_t     state;
    state_t     next_state;
    logic [5:0] count;
    logic       start;
    logic       busy;
    logic       last;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A new start in any state abandons whatever was in flight; multiply has priority.
    always_comb begin
        start      = ctrl_MULT | ctrl_DIV;
        busy       = (state == MULT) || (state == DIV);
        last       = (count == 6'(ITER));
        load_mult  = ctrl_MULT;
        load_div   = ctrl_DIV & ~ctrl_MULT;
        iterate    = busy && !start && !last;
        finalise   = busy && !start && last;
        mode_div   = (state == DIV);
        ready      = (state == DONE);
        next_state = state;
        if (load_mult) begin
            next_state = MULT;
        end else if (load_div) begin
            next_state = DIV;
        end else begin
            case (state)
                MULT, DIV: if (last) next_state = DONE;
                DONE:      next_state = IDLE;
                default:   next_state = state;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (iterate) begin
            count <= count + 6'd1;
        end
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit Booth multiplier / restoring divider built around one shared adder.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    import multdiv_pkg::*;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic             qm1;
    logic             neg_q;
    logic             div_zero;

    logic             load_mult;
    logic             load_div;
    logic             iterate;
    logic             finalise;
    logic             mode_div;
    booth_t           booth;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             shift_sign;

    multdiv_ctrl #(.ITER(ITER)) u_ctrl (
        .clock     (clock),
        .reset_n   (reset_n),
        .ctrl_MULT (ctrl_MULT),
        .ctrl_DIV  (ctrl_DIV),
        .load_mult (load_mult),
        .load_div  (load_div),
        .iterate   (iterate),
        .finalise  (finalise),
        .mode_div  (mode_div),
        .ready     (data_resultRDY)
    );

    assign booth = booth_decode(lo[0], qm1);

    // A negative divisor is added directly rather than negated, since -|B| == B in two's complement.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (load_div) begin
            add_b   = data_operandA[WIDTH-1] ? ~data_operandA : data_operandA;
            add_cin = data_operandA[WIDTH-1];
        end else if (iterate && mode_div) begin
            add_a   = {acc[WIDTH-2:0], lo[WIDTH-1]};
            add_b   = opnd[WIDTH-1] ? opnd : ~opnd;
            add_cin = ~opnd[WIDTH-1];
        end else if (iterate) begin
            add_a = acc;
            case (booth)
                ADD: add_b = opnd;
                SUB: begin
                    add_b   = ~opnd;
                    add_cin = 1'b1;
                end
                default: add_b = '0;
            endcase
        end else if (finalise && mode_div) begin
            add_b   = neg_q ? ~lo : lo;
            add_cin = neg_q;
        end
    end

    assign {carry, sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    // True sign of the 33-bit Booth partial sum, so overflow of acc is shifted back in correctly.
    assign shift_sign = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ carry;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc      <= '0;
            lo       <= '0;
            opnd     <= '0;
            qm1      <= 1'b0;
            neg_q    <= 1'b0;
            div_zero <= 1'b0;
        end else if (load_mult) begin
            acc      <= '0;
            lo       <= data_operandB;
            opnd     <= data_operandA;
            qm1      <= 1'b0;
            neg_q    <= 1'b0;
            div_zero <= 1'b0;
        end else if (load_div) begin
            acc      <= '0;
            lo       <= sum;
            opnd     <= data_operandB;
            qm1      <= 1'b0;
            neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
        end else if (iterate && mode_div) begin
            if (carry) begin
                acc <= sum;
                lo  <= {lo[WIDTH-2:0], 1'b1};
            end else begin
                acc <= add_a;
                lo  <= {lo[WIDTH-2:0], 1'b0};
            end
        end else if (iterate) begin
            acc <= {shift_sign, sum[WIDTH-1:1]};
            lo  <= {sum[0], lo[WIDTH-1:1]};
            qm1 <= lo[0];
        end
    end

    // Only the most-negative magnitude can overflow a quotient, and only when the sign is positive.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (finalise) begin
            if (!mode_div) begin
                data_result    <= lo;
                data_exception <= (acc != {WIDTH{lo[WIDTH-1]}});
            end else if (div_zero) begin
                data_result    <= '0;
                data_exception <= 1'b1;
            end else begin
                data_result    <= sum;
                data_exception <= (lo == INT_MIN) && !neg_q;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed corner cases plus random operations against an arithmetic model.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    multdiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Signed arithmetic reference: full 64-bit product, truncating division.
    function automatic void refModel(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic e);
        longint p;
        if (is_mult) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'h0) begin
            r = 32'h0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = $signed(a) / $signed(b);
            e = 1'b0;
        end
    endfunction

    // Operands are scrambled after the start edge to show they are not resampled.
    task automatic applyStimulus(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic awaitResult(input string tag, input logic [31:0] want_r, input logic want_e);
        int lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = k;
                break;
            end
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'd33);
        checkOutput({tag, " result"}, data_result, want_r);
        checkOutput({tag, " exception"}, 32'(data_exception), 32'(want_e));
        @(posedge clock);
        #1;
        checkOutput({tag, " strobe width"}, 32'(data_resultRDY), 32'd0);
        checkOutput({tag, " hold"}, data_result, want_r);
    endtask

    task automatic runDirected(input string tag, input logic m, input logic d, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] want_r, input logic want_e);
        applyStimulus(m, d, a, b);
        awaitResult(tag, want_r, want_e);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        e;
        logic        m;
        logic        seen;

        $display("[TB] starting multdiv_unit bench");
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset result", data_result, 32'h0);
        checkOutput("reset exception", 32'(data_exception), 32'h0);
        checkOutput("reset ready", 32'(data_resultRDY), 32'h0);
        reset_n = 1'b1;

        runDirected("mult 3*-4", 1'b1, 1'b0, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF4, 1'b0);
        runDirected("mult overflow", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
        runDirected("mult intmin*1", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
        runDirected("mult intmin*intmin", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1);
        runDirected("div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        runDirected("div by zero", 1'b0, 1'b1, 32'd7, 32'd0, 32'h0, 1'b1);
        runDirected("div intmin/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        runDirected("div intmin/1", 1'b0, 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
        runDirected("both starts", 1'b1, 1'b1, 32'd9, 32'd3, 32'd27, 1'b0);

        applyStimulus(1'b1, 1'b0, 32'd5, 32'd6);
        repeat (8) @(negedge clock);
        runDirected("restart div 100/7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0);

        applyStimulus(1'b1, 1'b0, 32'd123, 32'd456);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        checkOutput("midop reset result", data_result, 32'h0);
        checkOutput("midop reset exception", 32'(data_exception), 32'h0);
        checkOutput("midop reset ready", 32'(data_resultRDY), 32'h0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) seen = 1'b1;
        end
        checkOutput("midop reset no strobe", 32'(seen), 32'h0);
        runDirected("mult 2*2 after reset", 1'b1, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0);

        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 15)) - 32'd8;
                1: a = 32'($urandom_range(0, 255)) - 32'd128;
                default: ;
            endcase
            refModel(m, a, b, r, e);
            runDirected(m ? "random mult" : "random div", m, ~m, a, b, r, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
